// File: rtl/keypad_row_debouncer.sv
// Keypad row conditioning: per-row synchroniser and debouncer, with press/release
// event pulses and the index of the lowest pressed row.

module keypad_row_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync_lvl,
  output logic stable,
  output logic next_stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt, cnt_next;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Any return to the stable level throws away the partial count.
  always_comb begin
    next_stable = stable;
    cnt_next    = cnt;
    if (sync_lvl == stable) begin
      cnt_next = '0;
    end else if (cnt == LAST) begin
      next_stable = sync_lvl;
      cnt_next    = '0;
    end else begin
      cnt_next = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      stable <= next_stable;
      cnt    <= cnt_next;
    end
endmodule

module keypad_row_debouncer #(
  parameter int ROWS            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  localparam int IDX_W          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_in,
  output logic [ROWS-1:0]  row_sync,
  output logic [ROWS-1:0]  row_stable,
  output logic             any_pressed,
  output logic             multi_press,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [IDX_W-1:0] row_idx
);
  logic [ROWS-1:0] next_stable;
  logic            any_next;

  for (genvar g = 0; g < ROWS; g++) begin : g_ch
    keypad_row_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .raw        (row_in[g]),
      .sync_lvl   (row_sync[g]),
      .stable     (row_stable[g]),
      .next_stable(next_stable[g])
    );
  end

  function automatic logic [IDX_W-1:0] lowest_set(input logic [ROWS-1:0] v);
    lowest_set = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  assign any_next    = |next_stable;
  assign any_pressed = |row_stable;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_press = |(row_stable & (row_stable - ROWS'(1)));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      row_idx       <= '0;
    end else begin
      press_pulse   <= any_next & ~any_pressed;
      release_pulse <= ~any_next & any_pressed;
      if (any_next && !any_pressed) row_idx <= lowest_set(next_stable);
    end
endmodule
